lcd_capture: RTL and testbench
==============================

# lcd_capture

Video-stream capture block, the write-side counterpart of the LCD display path. It samples a parallel RGB888 stream qualified by vsync/de and converts each pixel to RGB565. Pixel pairs are packed into 32-bit words in the same layout the display path unpacks, and it issues DDR write strobes plus a frame-start address-reset pulse. It sits between the video source (camera/LCD-format bus) and the DDR write controller.

## Interface
- H_ACTIVE, 480, expected active pixels per line (even)
- V_ACTIVE, 272, expected active lines per frame
- lcd_clk  in  1  single clock; all logic on rising edge
- lcd_rst_n  in  1  asynchronous, active-low reset
- ddr_init_done  in  1  DDR ready; capture only while high
- cap_vsync  in  1  frame sync, active-low pulse; falling edge = frame boundary
- cap_de  in  1  pixel valid
- cap_r, cap_g, cap_b  in  8 each  RGB888 pixel
- ddr_wren  out  1  one-cycle write strobe for ddr_data
- ddr_data  out  32  packed word; first pixel in [31:16], second in [15:0]
- ddr_addr_set  out  1  one-cycle pulse at each captured frame start (write address reset)
- frame_done  out  1  one-cycle pulse when a captured frame closes
- line_cnt  out  10  lines captured in the last completed frame
- err_line  out  1  sticky format error, cleared at ddr_addr_set

## Operation
- Input stage: cap_* registered once (stage S1); edge detection on S1 vs previous S1.
- Pixel conversion: 16-bit halfword = {b[7:3], g[7:2], r[7:3]} (B in [15:11], G in [10:5], R in [4:0]).
- FSM states: IDLE, WAIT_VS, ACTIVE.
  - IDLE: outputs quiet; ddr_init_done=1 -> WAIT_VS.
  - WAIT_VS: vsync falling edge -> ddr_addr_set pulse, clear err_line and internal line counter, -> ACTIVE. A frame already in progress when WAIT_VS is entered is discarded.
  - ACTIVE: each de cycle: half=0 -> store halfword in hold, half<=1; half=1 -> ddr_data<={hold, pix}, ddr_wren=1, half<=0.
  - de falling edge: line counter +1. If half=1, flush ddr_data<={hold,16'h0000} with ddr_wren=1, half<=0, err_line<=1. If the line's pixel count != H_ACTIVE, err_line<=1.
  - vsync falling edge in ACTIVE: frame_done pulse, line_cnt<=counter, err_line<=1 if counter!=V_ACTIVE, then new frame start (ddr_addr_set, counter cleared, err_line cleared *after* the frame_done cycle, i.e. err_line of the closed frame is visible coincident with frame_done).
  - ddr_init_done=0 in any state -> IDLE next cycle, half cleared, no flush, no frame_done.
- Simultaneous de fall and vsync fall: line-end processing (including flush) happens first; ddr_wren, frame_done and ddr_addr_set may all assert in the same cycle.
- Pixel counter saturates at 2047; line counter saturates at 1023.

## Timing
- Reset values: ddr_wren=0, ddr_data=0, ddr_addr_set=0, frame_done=0, line_cnt=0, err_line=0, FSM=IDLE, half=0.
- Latency: pixel on cap_* at edge k -> S1 at k -> ddr_wren/ddr_data valid after edge k+1 (second pixel of pair); 2 cycles input-to-strobe.
- Line flush, frame_done, ddr_addr_set: asserted after edge k+1 for edge detected on S1 at k.
- ddr_wren never asserts on consecutive cycles except flush coinciding with a following pair (impossible when de is low on flush cycle). The sink must accept one word every 2 cycles at minimum.
- No back-pressure; the downstream DDR FIFO must absorb one write per two pixel clocks.

## Configuration
- LCD_CAPTURE_STATS_EN defined: pixel/line counters, line_cnt and err_line implemented as described.
- Undefined: counters removed, line_cnt=0 and err_line=0 constant; odd-line flush and frame_done still operate.

## Structure
- Package lcd_video_pkg: H_ACTIVE/V_ACTIVE defaults, FSM state enum, rgb888_to_rgb565 function.
- One sub-module: lcd_rgb_pack (conversion, hold register, half flag, flush); FSM and counters in top.

## Test plan
- Reset/idle: hold lcd_rst_n=0, then ddr_init_done=0 with full frames driven -> all outputs 0, no ddr_wren.
- Packing: pixel0 r=0x08,g=0x04,b=0x10, pixel1 all 0xFF -> ddr_data=0x1021FFFF, ddr_wren one cycle, 2 cycles after pixel1.
- Full frame 480x272: after first vsync fall -> ddr_addr_set once, 240 wren per line, 65280 per frame, frame_done at next vsync fall, line_cnt=272, err_line=0.
- Odd line (3 pixels) -> 2 wren, second word [15:0]=0x0000, err_line=1; cleared at next ddr_addr_set.
- ddr_init_done dropped mid-line -> no wren from next cycle; re-raised mid-frame -> no wren until after next vsync fall.
- de fall with half=1 coincident with vsync fall -> flush wren, frame_done and ddr_addr_set all in same cycle.

Source files
------------

// File: rtl/lcd_video_pkg.sv
// ---------------------------------------------------------------------------
// lcd_video_pkg
// Shared definitions for the LCD capture path:
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default active pixels per line / lines per frame
//   cap_state_e                 : capture FSM state encoding
//   rgb888_to_rgb565()          : pixel conversion, B in [15:11], G in [10:5], R in [4:0]
// ---------------------------------------------------------------------------
package lcd_video_pkg;

    localparam int unsigned H_ACTIVE_DEF = 480;
    localparam int unsigned V_ACTIVE_DEF = 272;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2
    } cap_state_e;

    // Truncating conversion; the low colour bits are dropped on purpose.
    function automatic logic [15:0] rgb888_to_rgb565(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        logic unused_low_bits;
        unused_low_bits = ^{r[2:0], g[1:0], b[2:0]};
        rgb888_to_rgb565 = {b[7:3], g[7:2], r[7:3]};
    endfunction

endpackage

// File: rtl/lcd_capture_if.sv
// ---------------------------------------------------------------------------
// lcd_capture_if
// Video-in / DDR-write bundle of the capture block.
//   ddr_init_done, cap_vsync, cap_de, cap_r/g/b : from the video source side
//   ddr_wren, ddr_data, ddr_addr_set            : towards the DDR write controller
// Modports: master = source/controller side, slave = lcd_capture.
// ---------------------------------------------------------------------------
interface lcd_capture_if;

    logic        ddr_init_done;
    logic        cap_vsync;
    logic        cap_de;
    logic [7:0]  cap_r;
    logic [7:0]  cap_g;
    logic [7:0]  cap_b;
    logic        ddr_wren;
    logic [31:0] ddr_data;
    logic        ddr_addr_set;

    modport master (
        output ddr_init_done, cap_vsync, cap_de, cap_r, cap_g, cap_b,
        input  ddr_wren, ddr_data, ddr_addr_set
    );

    modport slave (
        input  ddr_init_done, cap_vsync, cap_de, cap_r, cap_g, cap_b,
        output ddr_wren, ddr_data, ddr_addr_set
    );

endinterface

// File: rtl/lcd_rgb_pack.sv
// ---------------------------------------------------------------------------
// lcd_rgb_pack
// Converts RGB888 pixels to RGB565 and packs pairs into 32-bit words
// (first pixel in [31:16]). A line ending on an odd pixel is flushed with
// a zero lower halfword.
//   clk, rst_n      : clock, async active-low reset
//   clr             : drop any half-filled pair without flushing
//   pix_en          : pixel valid, pix_r/g/b : RGB888 pixel
//   line_end        : end of line, flushes a pending halfword
//   half            : a halfword is held waiting for its partner
//   wren, data      : registered write strobe and packed word
// ---------------------------------------------------------------------------
module lcd_rgb_pack
    import lcd_video_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        pix_en,
    input  logic        line_end,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic        half,
    output logic        wren,
    output logic [31:0] data
);

    logic [15:0] pix_s;
    logic [15:0] hold_r;
    logic        half_r;
    logic        wren_r;
    logic [31:0] data_r;

    assign pix_s = rgb888_to_rgb565(pix_r, pix_g, pix_b);
    assign half  = half_r;
    assign wren  = wren_r;
    assign data  = data_r;

    // Pair packing, odd-line flush and strobe generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= 16'h0000;
            half_r <= 1'b0;
            wren_r <= 1'b0;
            data_r <= 32'h0000_0000;
        end else if (clr) begin
            half_r <= 1'b0;
            wren_r <= 1'b0;
        end else if (pix_en) begin
            if (!half_r) begin
                hold_r <= pix_s;
                half_r <= 1'b1;
                wren_r <= 1'b0;
            end else begin
                data_r <= {hold_r, pix_s};
                half_r <= 1'b0;
                wren_r <= 1'b1;
            end
        end else if (line_end && half_r) begin
            data_r <= {hold_r, 16'h0000};
            half_r <= 1'b0;
            wren_r <= 1'b1;
        end else begin
            wren_r <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_capture.sv
// ---------------------------------------------------------------------------
// lcd_capture
// Captures an RGB888 vsync/de stream, packs RGB565 pixel pairs into 32-bit
// DDR write words and marks frame starts for the DDR write address.
//   lcd_clk, lcd_rst_n : clock, async active-low reset
//   bus (slave)        : video input and DDR write side (see lcd_capture_if)
//   frame_done         : one-cycle pulse when a captured frame closes
//   line_cnt           : lines captured in the last completed frame
//   err_line           : sticky format error, visible with frame_done,
//                        cleared the cycle after the new frame start
// Build option: LCD_CAPTURE_STATS_EN enables pixel/line counting, line_cnt and
// err_line; without it line_cnt and err_line are tied to zero.
// ---------------------------------------------------------------------------
module lcd_capture
    import lcd_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic         lcd_clk,
    input  logic         lcd_rst_n,
    lcd_capture_if.slave bus,
    output logic         frame_done,
    output logic [9:0]   line_cnt,
    output logic         err_line
);

    logic       s1_vsync_r, s1_de_r, s1p_vsync_r, s1p_de_r;
    logic [7:0] s1_red_r, s1_grn_r, s1_blu_r;
    cap_state_e state_r, state_s;
    logic       vs_fall_s, de_fall_s;
    logic       pix_en_s, line_end_s, frame_start_s, frame_close_s, pack_clr_s;
    logic       addr_set_r, frame_done_r;
    logic       half_s;

    assign vs_fall_s  = s1p_vsync_r & ~s1_vsync_r;
    assign de_fall_s  = s1p_de_r & ~s1_de_r;
    // Losing DDR ready abandons a half-filled pair instead of flushing it.
    assign pack_clr_s = ~bus.ddr_init_done | (state_r != ST_ACTIVE);

    // Input stage S1 plus the previous S1 sample for edge detection.
    always_ff @(posedge lcd_clk or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            s1_vsync_r  <= 1'b1;
            s1p_vsync_r <= 1'b1;
            s1_de_r     <= 1'b0;
            s1p_de_r    <= 1'b0;
            s1_red_r    <= 8'h00;
            s1_grn_r    <= 8'h00;
            s1_blu_r    <= 8'h00;
        end else begin
            s1_vsync_r  <= bus.cap_vsync;
            s1p_vsync_r <= s1_vsync_r;
            s1_de_r     <= bus.cap_de;
            s1p_de_r    <= s1_de_r;
            s1_red_r    <= bus.cap_r;
            s1_grn_r    <= bus.cap_g;
            s1_blu_r    <= bus.cap_b;
        end
    end

    // FSM state register and registered frame pulses.
    always_ff @(posedge lcd_clk or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            state_r      <= ST_IDLE;
            addr_set_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            addr_set_r   <= frame_start_s;
            frame_done_r <= frame_close_s;
        end
    end

    // Next state and per-cycle capture controls.
    always_comb begin
        state_s       = state_r;
        pix_en_s      = 1'b0;
        line_end_s    = 1'b0;
        frame_start_s = 1'b0;
        frame_close_s = 1'b0;
        if (!bus.ddr_init_done) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (vs_fall_s) begin
                        frame_start_s = 1'b1;
                        state_s       = ST_ACTIVE;
                    end else begin
                        state_s = ST_WAIT_VS;
                    end
                end
                ST_ACTIVE: begin
                    pix_en_s      = s1_de_r;
                    line_end_s    = de_fall_s;
                    frame_close_s = vs_fall_s;
                    frame_start_s = vs_fall_s;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    lcd_rgb_pack u_pack (
        .clk      (lcd_clk),
        .rst_n    (lcd_rst_n),
        .clr      (pack_clr_s),
        .pix_en   (pix_en_s),
        .line_end (line_end_s),
        .pix_r    (s1_red_r),
        .pix_g    (s1_grn_r),
        .pix_b    (s1_blu_r),
        .half     (half_s),
        .wren     (bus.ddr_wren),
        .data     (bus.ddr_data)
    );

    assign bus.ddr_addr_set = addr_set_r;
    assign frame_done       = frame_done_r;

`ifdef LCD_CAPTURE_STATS_EN
    localparam logic [10:0] PIX_MAX  = 11'd2047;
    localparam logic [9:0]  LINE_MAX = 10'd1023;

    logic [10:0] pix_cnt_r;
    logic [9:0]  line_ctr_r, line_cnt_r, line_inc_s, line_total_s;
    logic        err_line_r, err_clr_r, err_base_s, line_err_s, err_next_s;

    // Error and line-count bookkeeping; a line ending with the frame counts first.
    always_comb begin
        line_inc_s   = (line_ctr_r == LINE_MAX) ? line_ctr_r : line_ctr_r + 10'd1;
        line_total_s = line_end_s ? line_inc_s : line_ctr_r;
        err_base_s   = err_clr_r ? 1'b0 : err_line_r;
        line_err_s   = line_end_s & (half_s | (pix_cnt_r != 11'(H_ACTIVE)));
        if (frame_close_s) begin
            err_next_s = err_base_s | line_err_s | (line_total_s != 10'(V_ACTIVE));
        end else if (frame_start_s) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = err_base_s | line_err_s;
        end
    end

    // Pixel/line counters; err_line of a closed frame survives one cycle.
    always_ff @(posedge lcd_clk or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            pix_cnt_r  <= 11'd0;
            line_ctr_r <= 10'd0;
            line_cnt_r <= 10'd0;
            err_line_r <= 1'b0;
            err_clr_r  <= 1'b0;
        end else begin
            err_line_r <= err_next_s;
            err_clr_r  <= frame_close_s;
            if (pack_clr_s || line_end_s) begin
                pix_cnt_r <= 11'd0;
            end else if (pix_en_s && (pix_cnt_r != PIX_MAX)) begin
                pix_cnt_r <= pix_cnt_r + 11'd1;
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end
            if (frame_start_s) begin
                line_ctr_r <= 10'd0;
            end else if (line_end_s) begin
                line_ctr_r <= line_inc_s;
            end else begin
                line_ctr_r <= line_ctr_r;
            end
            if (frame_close_s) begin
                line_cnt_r <= line_total_s;
            end else begin
                line_cnt_r <= line_cnt_r;
            end
        end
    end

    assign line_cnt = line_cnt_r;
    assign err_line = err_line_r;
`else
    logic unused_stats_s;
    assign unused_stats_s = ^{half_s, 32'(H_ACTIVE), 32'(V_ACTIVE)};
    assign line_cnt       = 10'd0;
    assign err_line       = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// ---------------------------------------------------------------------------
// tb_lcd_capture
// Directed sequence with random pixel colours for lcd_capture, using a small
// frame geometry (8 x 4). Expected words come from a line-level model: each
// line's RGB565 halfwords are paired in order, an odd tail padded with zero.
// ---------------------------------------------------------------------------
module tb_lcd_capture;
    import lcd_video_pkg::*;

    localparam int H = 8;
    localparam int V = 4;
`ifdef LCD_CAPTURE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       lcd_clk = 1'b0;
    logic       lcd_rst_n;
    logic       frame_done;
    logic [9:0] line_cnt;
    logic       err_line;

    lcd_capture_if bus();

    lcd_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .lcd_clk    (lcd_clk),
        .lcd_rst_n  (lcd_rst_n),
        .bus        (bus),
        .frame_done (frame_done),
        .line_cnt   (line_cnt),
        .err_line   (err_line)
    );

    always #5 lcd_clk = ~lcd_clk;

    int checks = 0;
    int failures = 0;

    // Output monitor, sampled on the falling edge.
    int          cyc = 0, wr_cnt = 0, wr_cyc = 0, as_cnt = 0, as_cyc = 0;
    int          fd_cnt = 0, fd_cyc = 0, fd_lines = 0, consec = 0;
    logic        fd_err = 1'b0;
    logic        prev_wren = 1'b0;
    logic [31:0] got[$];

    always @(negedge lcd_clk) begin
        cyc       <= cyc + 1;
        prev_wren <= bus.ddr_wren;
        if (bus.ddr_wren === 1'b1) begin
            got.push_back(bus.ddr_data);
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc + 1;
            if (prev_wren === 1'b1) consec <= consec + 1;
        end
        if (bus.ddr_addr_set === 1'b1) begin
            as_cnt <= as_cnt + 1;
            as_cyc <= cyc + 1;
        end
        if (frame_done === 1'b1) begin
            fd_cnt   <= fd_cnt + 1;
            fd_cyc   <= cyc + 1;
            fd_lines <= int'(line_cnt);
            fd_err   <= err_line;
        end
    end

    logic [31:0] exp_q[$];
    int          got_base = 0;
    int          exp_base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge lcd_clk);
        #1;
    endtask

    task automatic vsync_pulse();
        bus.cap_vsync = 1'b0;
        repeat (2) step();
        bus.cap_vsync = 1'b1;
        repeat (2) step();
    endtask

    // Drives one line of n random pixels; optionally records expected words
    // and drops vsync together with de.
    task automatic drive_line(input int n, input bit cap, input bit vs_at_end);
        logic [15:0] px[$];
        int r, g, b;
        px = {};
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 255));
            g = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            bus.cap_de = 1'b1;
            bus.cap_r  = 8'(r);
            bus.cap_g  = 8'(g);
            bus.cap_b  = 8'(b);
            px.push_back(16'((b / 8) * 2048 + (g / 4) * 32 + (r / 8)));
            step();
        end
        bus.cap_de = 1'b0;
        if (vs_at_end) bus.cap_vsync = 1'b0;
        if (cap) begin
            for (int k = 0; k < n; k += 2)
                exp_q.push_back({px[k], (k + 1 < n) ? px[k + 1] : 16'h0000});
        end
        repeat (3) step();
        bus.cap_vsync = 1'b1;
        repeat (2) step();
    endtask

    task automatic check_words(input string tag);
        int n;
        n = exp_q.size() - exp_base;
        check({tag, "_count"}, 32'(got.size() - got_base), 32'(n));
        for (int j = 0; j < n; j++) begin
            if (got_base + j < got.size())
                check(tag, got[got_base + j], exp_q[exp_base + j]);
        end
        got_base = got.size();
        exp_base = exp_q.size();
    endtask

    initial begin
        int w0, w1, a0, f0, c0;
        bus.ddr_init_done = 1'b0;
        bus.cap_vsync     = 1'b1;
        bus.cap_de        = 1'b0;
        bus.cap_r         = 8'h00;
        bus.cap_g         = 8'h00;
        bus.cap_b         = 8'h00;
        lcd_rst_n         = 1'b0;
        repeat (3) step();

        check("rst_wren", 32'(bus.ddr_wren), 32'd0);
        check("rst_data", bus.ddr_data, 32'd0);
        check("rst_addr_set", 32'(bus.ddr_addr_set), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check("rst_err_line", 32'(err_line), 32'd0);

        // Full frame while DDR is not ready: nothing may come out.
        lcd_rst_n = 1'b1;
        step();
        w0 = wr_cnt; a0 = as_cnt; f0 = fd_cnt;
        vsync_pulse();
        for (int l = 0; l < V; l++) drive_line(H, 1'b0, 1'b0);
        vsync_pulse();
        check("idle_wren", 32'(wr_cnt - w0), 32'd0);
        check("idle_addr_set", 32'(as_cnt - a0), 32'd0);
        check("idle_frame_done", 32'(fd_cnt - f0), 32'd0);
        check("idle_data", bus.ddr_data, 32'd0);
        got_base = got.size();

        // Packing of a fixed pair and its latency.
        bus.ddr_init_done = 1'b1;
        repeat (2) step();
        a0 = as_cnt;
        vsync_pulse();
        check("start_addr_set", 32'(as_cnt - a0), 32'd1);
        w0 = wr_cnt;
        bus.cap_de = 1'b1; bus.cap_r = 8'h08; bus.cap_g = 8'h04; bus.cap_b = 8'h10;
        step();
        bus.cap_r = 8'hFF; bus.cap_g = 8'hFF; bus.cap_b = 8'hFF;
        c0 = cyc;
        step();
        bus.cap_de = 1'b0;
        repeat (4) step();
        exp_q.push_back(32'h1021_FFFF);
        check("pack_wren_count", 32'(wr_cnt - w0), 32'd1);
        check("pack_latency", 32'(wr_cyc), 32'(c0 + 3));
        check_words("pack_data");

        // Close the short frame: one line only, wrong length.
        f0 = fd_cnt;
        vsync_pulse();
        check("short_frame_done", 32'(fd_cnt - f0), 32'd1);
        check("short_line_cnt", 32'(fd_lines), STATS ? 32'd1 : 32'd0);
        check("short_err", 32'(fd_err), 32'(STATS));
        check("short_err_cleared", 32'(err_line), 32'd0);

        // Well-formed frame.
        w0 = wr_cnt; f0 = fd_cnt;
        for (int l = 0; l < V; l++) drive_line(H, 1'b1, 1'b0);
        check("full_err_midframe", 32'(err_line), 32'd0);
        vsync_pulse();
        check("full_wren", 32'(wr_cnt - w0), 32'(V * H / 2));
        check_words("full_data");
        check("full_frame_done", 32'(fd_cnt - f0), 32'd1);
        check("full_line_cnt", 32'(fd_lines), STATS ? 32'(V) : 32'd0);
        check("full_err", 32'(fd_err), 32'd0);

        // Frame with a 3-pixel line.
        drive_line(H, 1'b1, 1'b0);
        w0 = wr_cnt;
        drive_line(3, 1'b1, 1'b0);
        check("odd_wren", 32'(wr_cnt - w0), 32'd2);
        check("odd_flush_low", 32'(got[got.size() - 1][15:0]), 32'd0);
        check("odd_err_set", 32'(err_line), 32'(STATS));
        drive_line(H, 1'b1, 1'b0);
        drive_line(H, 1'b1, 1'b0);
        vsync_pulse();
        check_words("odd_data");
        check("odd_frame_err", 32'(fd_err), 32'(STATS));
        check("odd_line_cnt", 32'(fd_lines), STATS ? 32'(V) : 32'd0);
        check("odd_err_cleared", 32'(err_line), 32'd0);

        // DDR ready dropped mid-line, then restored mid-frame.
        f0 = fd_cnt;
        w1 = wr_cnt;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) bus.ddr_init_done = 1'b0;
            bus.cap_de = 1'b1;
            bus.cap_r  = 8'($urandom_range(0, 255));
            bus.cap_g  = 8'($urandom_range(0, 255));
            bus.cap_b  = 8'($urandom_range(0, 255));
            if (i < 4 && (i % 2) == 1) exp_q.push_back(32'h0);
            step();
            if (i == 6) w1 = wr_cnt;
        end
        bus.cap_de = 1'b0;
        repeat (3) step();
        check("drop_no_wren", 32'(wr_cnt - w1), 32'd0);
        check("drop_words_before", 32'(got.size() - got_base), 32'd2);
        got_base = got.size();
        exp_base = exp_q.size();
        bus.ddr_init_done = 1'b1;
        step();
        drive_line(H, 1'b0, 1'b0);
        drive_line(H, 1'b0, 1'b0);
        check("reraise_no_wren", 32'(wr_cnt - w1), 32'd0);
        a0 = as_cnt;
        vsync_pulse();
        check("reraise_addr_set", 32'(as_cnt - a0), 32'd1);
        check("reraise_no_frame_done", 32'(fd_cnt - f0), 32'd0);
        drive_line(H, 1'b1, 1'b0);

        // Odd line ending together with vsync.
        f0 = fd_cnt; a0 = as_cnt;
        drive_line(5, 1'b1, 1'b1);
        check_words("coinc_data");
        check("coinc_frame_done", 32'(fd_cnt - f0), 32'd1);
        check("coinc_addr_set", 32'(as_cnt - a0), 32'd1);
        check("coinc_wren_fd_cycle", 32'(wr_cyc), 32'(fd_cyc));
        check("coinc_as_fd_cycle", 32'(as_cyc), 32'(fd_cyc));
        check("coinc_line_cnt", 32'(fd_lines), STATS ? 32'd2 : 32'd0);
        check("coinc_err", 32'(fd_err), 32'(STATS));
        check("line_cnt_held", 32'(line_cnt), STATS ? 32'd2 : 32'd0);
        check("no_back_to_back", 32'(consec), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
